// File: rtl/demux_stream_1to2.sv
// rtl/demux_stream_1to2.sv - registered 1-to-2 stream demux with per-channel holding registers
module demux_stream_1to2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             rr_en,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } rr_state_t;

    rr_state_t        rr_state_q, rr_state_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic             y0_valid_q, y0_valid_d;
    logic             y1_valid_q, y1_valid_d;
    logic [15:0]      cnt0_q, cnt0_d;
    logic [15:0]      cnt1_q, cnt1_d;

    logic dest;
    logic dest_valid;
    logic dest_ready;
    logic accept;

    // Destination select and accept; only the destination channel can stall the input
    always_comb begin
        dest       = rr_en ? (rr_state_q == CH1) : sel;
        dest_valid = dest ? y1_valid_q : y0_valid_q;
        dest_ready = dest ? y1_ready   : y0_ready;
        in_ready   = !rst && (!dest_valid || dest_ready);
        accept     = in_valid && in_ready;
    end

    // Round-robin pointer advances only on accepted words while round-robin is enabled
    always_comb begin
        rr_state_d = rr_state_q;
        if (rr_en && accept) begin
            rr_state_d = (rr_state_q == CH0) ? CH1 : CH0;
        end
    end

    // Channel holding registers: load on accept (wins over drain), else clear valid on drain
    always_comb begin
        y0_d       = y0_q;
        y1_d       = y1_q;
        y0_valid_d = y0_valid_q;
        y1_valid_d = y1_valid_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        if (accept && !dest) begin
            y0_d       = d;
            y0_valid_d = 1'b1;
            cnt0_d     = cnt0_q + 16'd1;
        end else if (y0_valid_q && y0_ready) begin
            y0_valid_d = 1'b0;
        end

        if (accept && dest) begin
            y1_d       = d;
            y1_valid_d = 1'b1;
            cnt1_d     = cnt1_q + 16'd1;
        end else if (y1_valid_q && y1_ready) begin
            y1_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held words immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_state_q <= CH0;
            y0_q       <= '0;
            y1_q       <= '0;
            y0_valid_q <= 1'b0;
            y1_valid_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            rr_state_q <= rr_state_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            y0_valid_q <= y0_valid_d;
            y1_valid_q <= y1_valid_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign y0       = y0_q;
    assign y1       = y1_q;
    assign y0_valid = y0_valid_q;
    assign y1_valid = y1_valid_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux_stream_1to2.sv
// tb/tb_demux_stream_1to2.sv - directed self-checking bench for demux_stream_1to2
module tb_demux_stream_1to2;

    logic        clk;
    logic        rst;
    logic [7:0]  d;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic        rr_en;
    logic [7:0]  y0;
    logic        y0_valid;
    logic        y0_ready;
    logic [7:0]  y1;
    logic        y1_valid;
    logic        y1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int total;
    int bad;

    demux_stream_1to2 #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .rr_en    (rr_en),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset with a valid word presented; nothing may be accepted or delivered
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; d = 8'hFF; sel = 1'b0; rr_en = 1'b0;
        y0_ready = 1'b1; y1_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (y0 !== 8'h00 || y1 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h/%h exp=00/00", y0, y1); end
        total++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b/%b exp=0/0", y0_valid, y1_valid); end
        total++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0 || cnt0 !== 16'd0) begin
            bad++; $display("FAIL reset_release got=%b/%b cnt0=%0d exp=0/0 cnt0=0", y0_valid, y1_valid, cnt0);
        end
    endtask

    // Single word via sel to channel 0, visible for exactly one cycle
    task automatic test_sel_mode();
        rr_en = 1'b0; sel = 1'b0; d = 8'hA5; in_valid = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sel_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (y0 !== 8'hA5 || y0_valid !== 1'b1) begin bad++; $display("FAIL sel_y0 got=%h v=%b exp=a5 v=1", y0, y0_valid); end
        total++; if (cnt0 !== 16'd1) begin bad++; $display("FAIL sel_cnt0 got=%0d exp=1", cnt0); end
        total++; if (y1_valid !== 1'b0) begin bad++; $display("FAIL sel_y1_valid got=%b exp=0", y1_valid); end
        @(negedge clk);
        total++; if (y0_valid !== 1'b0 || y0 !== 8'hA5) begin bad++; $display("FAIL sel_y0_drain got=%h v=%b exp=a5 v=0", y0, y0_valid); end
    endtask

    // Channel 1 stalled: second word blocked until consumer ready, then in-order delivery
    task automatic test_backpressure();
        y1_ready = 1'b0; sel = 1'b1; d = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        d = 8'h22;
        #1;
        total++; if (y1 !== 8'h11 || y1_valid !== 1'b1) begin bad++; $display("FAIL bp_hold11 got=%h v=%b exp=11 v=1", y1, y1_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_stall got=%b exp=0", in_ready); end
        @(negedge clk);
        total++; if (y1 !== 8'h11 || cnt1 !== 16'd1) begin bad++; $display("FAIL bp_still11 got=%h cnt1=%0d exp=11 cnt1=1", y1, cnt1); end
        y1_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_resume got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (y1 !== 8'h22 || y1_valid !== 1'b1 || cnt1 !== 16'd2) begin
            bad++; $display("FAIL bp_22 got=%h v=%b cnt1=%0d exp=22 v=1 cnt1=2", y1, y1_valid, cnt1);
        end
        @(negedge clk);
        total++; if (y1_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", y1_valid); end
    endtask

    // Round-robin back-to-back: 01,03 to ch0 and 02,04 to ch1 at full rate
    task automatic test_round_robin();
        logic [7:0] got;
        logic       got_v;
        logic       oth_v;
        rr_en = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1; sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                got   = ((i - 1) % 2 == 0) ? y0 : y1;
                got_v = ((i - 1) % 2 == 0) ? y0_valid : y1_valid;
                oth_v = ((i - 1) % 2 == 0) ? y1_valid : y0_valid;
                total++; if (got !== 8'(i) || got_v !== 1'b1 || oth_v !== 1'b0) begin
                    bad++; $display("FAIL rr_word%0d got=%h v=%b other_v=%b exp=%h v=1 other_v=0", i, got, got_v, oth_v, 8'(i));
                end
            end
            if (i < 4) begin
                d = 8'(i + 1); in_valid = 1'b1;
                #1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_in_ready%0d got=%b exp=1", i, in_ready); end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        // earlier tests left cnt0=1, cnt1=2; two more each
        total++; if (cnt0 !== 16'd3 || cnt1 !== 16'd4) begin bad++; $display("FAIL rr_cnt got=%0d/%0d exp=3/4", cnt0, cnt1); end
    endtask

    // Pointer at CH0 with ch0 full and stalled: ch1 must not be used
    task automatic test_hol_blocking();
        @(negedge clk);
        rr_en = 1'b1; y0_ready = 1'b0; y1_ready = 1'b1; d = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        d = 8'h66;
        @(negedge clk);
        d = 8'h77;
        #1;
        total++; if (y0 !== 8'h55 || y0_valid !== 1'b1 || y1 !== 8'h66 || y1_valid !== 1'b1) begin
            bad++; $display("FAIL hol_fill got=%h/%b %h/%b exp=55/1 66/1", y0, y0_valid, y1, y1_valid);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hol_in_ready got=%b exp=0", in_ready); end
        repeat (2) @(negedge clk);
        total++; if (y1_valid !== 1'b0 || cnt1 !== 16'd5 || in_ready !== 1'b0) begin
            bad++; $display("FAIL hol_block got=v1=%b cnt1=%0d rdy=%b exp=v1=0 cnt1=5 rdy=0", y1_valid, cnt1, in_ready);
        end
        total++; if (y0 !== 8'h55 || y0_valid !== 1'b1) begin bad++; $display("FAIL hol_y0_stable got=%h v=%b exp=55 v=1", y0, y0_valid); end
        y0_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hol_resume_rdy got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (y0 !== 8'h77 || y0_valid !== 1'b1 || y1_valid !== 1'b0 || cnt0 !== 16'd5) begin
            bad++; $display("FAIL hol_resume got=%h v0=%b v1=%b cnt0=%0d exp=77 v0=1 v1=0 cnt0=5", y0, y0_valid, y1_valid, cnt0);
        end
    endtask

    // 65536 transfers wrap cnt0 to zero, then an async reset clears the held word without a clock edge
    task automatic test_wrap_async_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rr_en = 1'b0; sel = 1'b0; y0_ready = 1'b1; d = 8'h5A; in_valid = 1'b1;
        repeat (65535) @(negedge clk);
        total++; if (cnt0 !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", cnt0); end
        @(negedge clk);
        total++; if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=0000/0000", cnt0, cnt1); end
        total++; if (y0 !== 8'h5A || y0_valid !== 1'b1) begin bad++; $display("FAIL wrap_y0 got=%h v=%b exp=5a v=1", y0, y0_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (y0_valid !== 1'b0 || y0 !== 8'h00) begin bad++; $display("FAIL async_rst_y0 got=%h v=%b exp=00 v=0", y0, y0_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL async_rst_rdy got=%b exp=0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++; if (y0_valid !== 1'b0 || cnt0 !== 16'd0) begin bad++; $display("FAIL post_rst got=v=%b cnt0=%0d exp=v=0 cnt0=0", y0_valid, cnt0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sel_mode();
        test_backpressure();
        test_round_robin();
        test_hol_blocking();
        test_wrap_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
